// File: rtl/divider_pkg.sv
// Shared constants and FSM state type for the restoring 8-bit divider.
package divider_pkg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned ITERS = 8;
  localparam int unsigned CNT_W = $clog2(ITERS);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and keep or restore the partial remainder.
module div_step
  import divider_pkg::*;
#(
  parameter int unsigned N = WIDTH
) (
  input  logic [N-1:0] i_rem,
  input  logic [N-1:0] i_quo,
  input  logic [N-1:0] i_div,
  output logic [N-1:0] o_rem,
  output logic [N-1:0] o_quo
);

  logic [N:0] w_shift;
  logic [N:0] w_diff;
  logic       w_ge;

  assign w_shift = {i_rem, i_quo[N-1]};
  assign w_diff  = w_shift - {1'b0, i_div};
  // Partial remainder is always below the divisor, so the N+1-bit difference
  // never overflows and its top bit is a reliable sign.
  assign w_ge    = ~w_diff[N];

  // Select difference or restored value and shift in the new quotient bit.
  always_comb begin
    o_rem = w_ge ? w_diff[N-1:0] : w_shift[N-1:0];
    o_quo = {i_quo[N-2:0], w_ge};
  end

endmodule

// File: rtl/restoring_8_bit_divider.sv
// Restoring 8-bit divider: FSM IDLE -> CALC (8 iterations) -> FIX -> DONE.
// A zero divisor skips CALC and reports DZ with Q=FF, R=A.
// Optional macro DIVIDER_SIGNED_EN enables two's-complement mode via Cont;
// without it Cont is ignored and OF is always 0.
module restoring_8_bit_divider
  import divider_pkg::*;
#(
  parameter int unsigned N = WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  input  logic         Cont,
  output logic [N-1:0] Q,
  output logic [N-1:0] R,
  output logic         busy,
  output logic         done,
  output logic         DZ,
  output logic         OF
);

  state_t             r_state;
  state_t             w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [N-1:0]       r_rem;
  logic [N-1:0]       r_quo;
  logic [N-1:0]       r_div;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_ovf;
  logic               r_zero;
  logic [N-1:0]       r_q;
  logic [N-1:0]       r_r;
  logic               r_dz;
  logic               r_of;

  logic               w_signed;
  logic               w_zero;
  logic [N-1:0]       w_a_mag;
  logic [N-1:0]       w_b_mag;
  logic [N-1:0]       w_rem_next;
  logic [N-1:0]       w_quo_next;

`ifdef DIVIDER_SIGNED_EN
  assign w_signed = Cont;
`else
  logic w_unused_cont;
  assign w_unused_cont = Cont;
  assign w_signed      = 1'b0;
`endif

  assign w_zero  = (B == '0);
  assign w_a_mag = (w_signed && A[N-1]) ? -A : A;
  assign w_b_mag = (w_signed && B[N-1]) ? -B : B;

  div_step #(
    .N (N)
  ) u_div_step (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_div (r_div),
    .o_rem (w_rem_next),
    .o_quo (w_quo_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic; a zero divisor routes through FIX so DONE lands one edge later.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (start) w_state_next = w_zero ? FIX : CALC;
      CALC: if (r_cnt == CNT_W'(ITERS - 1)) w_state_next = FIX;
      FIX:  w_state_next = DONE;
      DONE: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Operand latch, iteration datapath and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_div   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
      r_q     <= '0;
      r_r     <= '0;
      r_dz    <= 1'b0;
      r_of    <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            // For a zero divisor the dividend parks in r_rem to become R.
            r_rem   <= w_zero ? A : '0;
            r_quo   <= w_a_mag;
            r_div   <= w_b_mag;
            r_neg_q <= !w_zero && w_signed && (A[N-1] ^ B[N-1]);
            r_neg_r <= !w_zero && w_signed && A[N-1];
            r_ovf   <= w_signed && (A == {1'b1, {(N-1){1'b0}}}) && (B == '1);
            r_zero  <= w_zero;
            r_dz    <= 1'b0;
            r_of    <= 1'b0;
          end
        end
        CALC: begin
          r_rem <= w_rem_next;
          r_quo <= w_quo_next;
          r_cnt <= r_cnt + 1'b1;
        end
        FIX: begin
          if (r_zero) begin
            r_q  <= '1;
            r_r  <= r_rem;
            r_dz <= 1'b1;
            r_of <= 1'b0;
          end else begin
            r_q  <= r_neg_q ? -r_quo : r_quo;
            r_r  <= r_neg_r ? -r_rem : r_rem;
            r_of <= r_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != IDLE);
  assign done = (r_state == DONE);
  assign Q    = r_q;
  assign R    = r_r;
  assign DZ   = r_dz;
  assign OF   = r_of;

endmodule

// File: tb/tb_restoring_8_bit_divider.sv
// Directed bench for restoring_8_bit_divider; expected values hand-computed.
// Signed expectations apply when DIVIDER_SIGNED_EN is defined, otherwise the
// same vectors are checked as unsigned divisions.
module tb_restoring_8_bit_divider;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] A;
  logic [7:0] B;
  logic       Cont;
  logic [7:0] Q;
  logic [7:0] R;
  logic       busy;
  logic       done;
  logic       DZ;
  logic       OF;

  int n_tests;
  int n_fail;

  restoring_8_bit_divider #(
    .N (8)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .Cont  (Cont),
    .Q     (Q),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .DZ    (DZ),
    .OF    (OF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one operation, scramble operands after acceptance, wait for done.
  task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic c, input int exp_lat, input logic [7:0] eq,
                        input logic [7:0] er, input logic edz, input logic eof);
    int lat;
    @(negedge clk);
    A = a; B = b; Cont = c; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; A = ~a; B = 8'h00; Cont = ~c;
    check_eq({tag, "_busy"}, 16'(busy), 16'd1);
    check_eq({tag, "_flags_clr"}, {14'd0, DZ, OF}, 16'd0);
    lat = 0;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq({tag, "_lat"}, 16'(lat), 16'(exp_lat));
    check_eq({tag, "_Q"}, 16'(Q), 16'(eq));
    check_eq({tag, "_R"}, 16'(R), 16'(er));
    check_eq({tag, "_DZ"}, 16'(DZ), 16'(edz));
    check_eq({tag, "_OF"}, 16'(OF), 16'(eof));
    @(posedge clk); #1;
    check_eq({tag, "_pulse"}, {14'd0, done, busy}, 16'd0);
    check_eq({tag, "_hold"}, {Q, R}, {eq, er});
  endtask

  initial begin
    int lat;
    int n_done;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; start = 1'b0; A = 8'h00; B = 8'h00; Cont = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out", {Q, R}, 16'h0000);
    check_eq("rst_flags", {12'd0, busy, done, DZ, OF}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op("u200_7", 8'd200, 8'd7, 1'b0, 9, 8'd28, 8'd4, 1'b0, 1'b0);
    run_op("dz55", 8'h55, 8'h00, 1'b0, 1, 8'hFF, 8'h55, 1'b1, 1'b0);
    run_op("u255_1", 8'hFF, 8'h01, 1'b0, 9, 8'hFF, 8'h00, 1'b0, 1'b0);
    run_op("u7_9", 8'd7, 8'd9, 1'b0, 9, 8'd0, 8'd7, 1'b0, 1'b0);
    run_op("u255_255", 8'hFF, 8'hFF, 1'b0, 9, 8'd1, 8'd0, 1'b0, 1'b0);
    run_op("u80_ff", 8'h80, 8'hFF, 1'b0, 9, 8'h00, 8'h80, 1'b0, 1'b0);
`ifdef DIVIDER_SIGNED_EN
    run_op("sm100_7", 8'h9C, 8'h07, 1'b1, 9, 8'hF2, 8'hFE, 1'b0, 1'b0);
    run_op("s100_m7", 8'h64, 8'hF9, 1'b1, 9, 8'hF2, 8'h02, 1'b0, 1'b0);
    run_op("s_ovf", 8'h80, 8'hFF, 1'b1, 9, 8'h80, 8'h00, 1'b0, 1'b1);
    run_op("sm7_m2", 8'hF9, 8'hFE, 1'b1, 9, 8'h03, 8'hFF, 1'b0, 1'b0);
`else
    run_op("sm100_7", 8'h9C, 8'h07, 1'b1, 9, 8'h16, 8'h02, 1'b0, 1'b0);
    run_op("s100_m7", 8'h64, 8'hF9, 1'b1, 9, 8'h00, 8'h64, 1'b0, 1'b0);
    run_op("s_ovf", 8'h80, 8'hFF, 1'b1, 9, 8'h00, 8'h80, 1'b0, 1'b0);
    run_op("sm7_m2", 8'hF9, 8'hFE, 1'b1, 9, 8'h00, 8'hF9, 1'b0, 1'b0);
`endif

    // Second start at cycle 3 of a busy operation must be ignored.
    @(negedge clk);
    A = 8'd200; B = 8'd7; Cont = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    A = 8'd10; B = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 3;
    while (!done && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check_eq("busy_lat", 16'(lat), 16'd9);
    check_eq("busy_QR", {Q, R}, {8'd28, 8'd4});
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done) n_done++;
    end
    check_eq("busy_single_done", 16'(n_done), 16'd0);

    // Reset at cycle 5 aborts the operation with no done pulse.
    @(negedge clk);
    A = 8'd100; B = 8'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("abort_out", {Q, R}, 16'h0000);
    check_eq("abort_flags", {12'd0, busy, done, DZ, OF}, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done || busy) n_done++;
    end
    check_eq("abort_no_done", 16'(n_done), 16'd0);
    run_op("fresh", 8'd200, 8'd7, 1'b0, 9, 8'd28, 8'd4, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/restoring_8_bit_divider.md
RESTORING_8_BIT_DIVIDER -- requirements
Module: restoring_8_bit_divider

Interface
REQ-001 The block SHALL have parameter N, default 8, giving the operand width; only N=8 is supported.
REQ-002 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 The block SHALL have port start  input  1  request, sampled only in IDLE.
REQ-005 The block SHALL have port A  input  8  dividend.
REQ-006 The block SHALL have port B  input  8  divisor.
REQ-007 The block SHALL have port Cont  input  1  control bit: 0 unsigned, 1 signed (two's complement).
REQ-008 The block SHALL have port Q  output  8  quotient.
REQ-009 The block SHALL have port R  output  8  remainder.
REQ-010 The block SHALL have port busy  output  1  high from accepted start through the DONE cycle.
REQ-011 The block SHALL have port done  output  1  one-cycle pulse; Q/R/DZ/OF valid.
REQ-012 The block SHALL have port DZ  output  1  divide-by-zero flag.
REQ-013 The block SHALL have port OF  output  1  signed overflow flag.

Function
REQ-014 The block SHALL implement states IDLE, CALC, FIX and DONE.
REQ-015 On an edge t in IDLE with start=1 and B!=0, the block SHALL latch A, B and Cont and enter CALC with the iteration counter at 0.
REQ-016 In CALC, for 8 edges (t+1..t+8), the block SHALL run one restoring iteration per edge: shift {rem,quo} left 1; trial-subtract |B|; if non-negative, keep the difference and set the quotient LSB to 1; else restore and set it to 0; after the 8th iteration it SHALL enter FIX.
REQ-017 At edge t+9, FIX SHALL apply sign correction and register Q/R/OF, then enter DONE.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle (t+9 to t+10), after which the block SHALL return to IDLE.
REQ-019 Latency from start to done SHALL be a constant 9 cycles for every non-zero divisor.
REQ-020 Signed mode SHALL divide magnitudes; Q SHALL be negated when A[7]^B[7]; R SHALL take the sign of A (truncating division).
REQ-021 On start with B==0, the block SHALL go directly to DONE at t+1 with DZ=1, Q=8'hFF and R=A; OF SHALL be 0.
REQ-022 For Cont=1, A=8'h80 and B=8'hFF, the block SHALL return Q=8'h80, R=8'h00 and OF=1.
REQ-023 OF SHALL always be 0 in unsigned mode.
REQ-024 A start asserted while busy=1 SHALL be ignored.
REQ-025 Operand changes after acceptance SHALL have no effect.
REQ-026 Q, R, DZ and OF SHALL hold their values until the next done.
REQ-027 DZ and OF SHALL be cleared when a new start is accepted.

Reset
REQ-028 With rst=1 at an edge, the block SHALL go to IDLE and set Q=0, R=0, busy=0, done=0, DZ=0, OF=0 and clear the counter.
REQ-029 Reset SHALL take priority over start and SHALL abort any operation in progress with no done pulse.

Configuration
REQ-030 With macro DIVIDER_SIGNED_EN defined, the block SHALL support signed division per REQ-020 to REQ-022.
REQ-031 Without DIVIDER_SIGNED_EN, the block SHALL ignore Cont, perform unsigned division only, tie OF to 0, and still pass through FIX so latency stays 9 cycles.

Structure
REQ-032 Package divider_pkg SHALL hold the state enum (IDLE/CALC/FIX/DONE), the width constant (8) and the iteration count constant (8).
REQ-033 One sub-module, div_step, SHALL implement a single combinational restoring iteration (inputs: partial remainder, quotient, divisor; outputs: next remainder, next quotient); the top SHALL hold the FSM, counter and registers.

Verification
REQ-034 Unsigned case: Cont=0, A=200, B=7 -> done 9 cycles after start, Q=28, R=4, DZ=0, OF=0.
REQ-035 Signed case: Cont=1, A=-100 (8'h9C), B=7 -> Q=-14 (8'hF2), R=-2 (8'hFE), OF=0; also A=100, B=-7 -> Q=8'hF2, R=8'h02.
REQ-036 Divide by zero: A=8'h55, B=0 -> done 1 cycle after start, DZ=1, Q=8'hFF, R=8'h55.
REQ-037 Signed overflow: Cont=1, A=8'h80, B=8'hFF -> Q=8'h80, R=0, OF=1; the same operands with Cont=0 -> Q=0, R=8'h80, OF=0.
REQ-038 Busy and reset: start pulsed again at cycle 3 of a busy operation -> ignored, single done; rst=1 at cycle 5 -> all outputs 0, IDLE, no done; a fresh start then completes normally.
